// File: rtl/n64a_vmux.sv
// n64a_vmux: serialises buffered pixels onto the N64 VD bus as sync/R/G/B frames.
// Optional N64A_VMUX_TESTPAT_EN adds testpat_i, which replaces popped colours with a ramp.
module n64a_vmux #(
   parameter int color_width = 7,
   parameter int sync_width  = 4
) (
   input  logic                   VCLK,
   input  logic                   nRST,
`ifdef N64A_VMUX_TESTPAT_EN
   input  logic                   testpat_i,
`endif
   input  logic                   pix_valid_i,
   output logic                   pix_ready_o,
   input  logic [sync_width-1:0]  pix_sync_i,
   input  logic [color_width-1:0] pix_r_i,
   input  logic [color_width-1:0] pix_g_i,
   input  logic [color_width-1:0] pix_b_i,
   input  logic                   n16bit_mode_i,
   output logic                   nVDSYNC,
   output logic [color_width-1:0] VD_o,
   output logic                   underrun_o
);
   localparam int W = sync_width + 3 * color_width;
   logic [W-1:0]           mem_q [2];
   logic                   wp_q, rp_q, push, pop;
   logic [1:0]             p_q, p_d, cnt_q, cnt_d;
   logic [sync_width-1:0]  sync_q, sync_d, hs;
   logic [color_width-1:0] r_q, r_d, g_q, g_d, b_q, b_d, hr, hg, hb, pr, pg, pb;
   logic [color_width-1:0] mr, mg, mb, vd_q, vd_d;
   logic                   nvd_q, nvd_d, und_q, und_d;
   assign pix_ready_o = cnt_q < 2'd2;
   assign nVDSYNC     = nvd_q;
   assign VD_o        = vd_q;
   assign underrun_o  = und_q;
   assign {hs, hr, hg, hb} = mem_q[rp_q];
`ifdef N64A_VMUX_TESTPAT_EN
   logic [color_width-1:0] tc_q, tc_d;
   always_comb begin
      tc_d = pop ? (hs[1] ? tc_q + 1'b1 : '0) : tc_q;
      pr   = testpat_i ? tc_d : hr;
      pg   = testpat_i ? tc_d : hg;
      pb   = testpat_i ? tc_d : hb;
   end
   always_ff @(posedge VCLK or negedge nRST)
      if (!nRST) tc_q <= '0;
      else       tc_q <= tc_d;
`else
   assign pr = hr;
   assign pg = hg;
   assign pb = hb;
`endif
   always_comb begin
      p_d    = p_q + 2'd1;
      push   = pix_valid_i && pix_ready_o;
      pop    = (p_q == 2'd0) && (cnt_q != 2'd0);
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      sync_d = pop ? hs : sync_q;
      r_d    = (p_q == 2'd0) ? (pop ? pr : '0) : r_q;
      g_d    = (p_q == 2'd0) ? (pop ? pg : '0) : g_q;
      b_d    = (p_q == 2'd0) ? (pop ? pb : '0) : b_q;
      mr     = n16bit_mode_i ? r_q : {r_q[color_width-1:2], 2'b00};
      mg     = n16bit_mode_i ? g_q : {g_q[color_width-1:1], 1'b0};
      mb     = n16bit_mode_i ? b_q : {b_q[color_width-1:2], 2'b00};
      vd_d   = (p_q == 2'd0) ? {{(color_width-sync_width){1'b0}}, sync_d} :
               (p_q == 2'd1) ? mr : (p_q == 2'd2) ? mg : mb;
      nvd_d  = p_q != 2'd0;
      und_d  = (p_q == 2'd0) && (cnt_q == 2'd0);
   end
   // storage is never reset; the count alone decides which entries are live
   always_ff @(posedge VCLK)
      if (push) mem_q[wp_q] <= {pix_sync_i, pix_r_i, pix_g_i, pix_b_i};
   always_ff @(posedge VCLK or negedge nRST)
      if (!nRST) begin
         p_q    <= '0;
         cnt_q  <= '0;
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         sync_q <= '1;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         nvd_q  <= 1'b1;
         vd_q   <= '0;
         und_q  <= 1'b0;
      end else begin
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         wp_q   <= wp_q ^ push;
         rp_q   <= rp_q ^ pop;
         sync_q <= sync_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         nvd_q  <= nvd_d;
         vd_q   <= vd_d;
         und_q  <= und_d;
      end
endmodule
